// File: rtl/neuron_update_scheduler_if.sv
// Spike event handshake between the neuron update scheduler (master) and the
// spike consumer (slave).
interface neuron_update_scheduler_if #(
  parameter int ADDR_W = 5
);
  logic              spike_valid;
  logic [ADDR_W-1:0] spike_id;
  logic              spike_ready;

  modport master (output spike_valid, output spike_id, input spike_ready);
  modport slave  (input spike_valid, input spike_id, output spike_ready);
endinterface

// File: rtl/neuron_update_scheduler.sv
// Timestep sequencer for the shared LIF potential adder: walks every neuron,
// feeds the adder, writes potentials back and emits spike events.
module neuron_update_scheduler #(
  parameter int NUM_NEURONS = 20,
  parameter int ADDR_W      = 5,
  parameter int ADD_LAT     = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic                      mem_rd_en,
  output logic [ADDR_W-1:0]         mem_addr,
  input  logic [31:0]               wgt_rd_data,
  input  logic [31:0]               pot_rd_data,
  output logic [31:0]               adder_weight,
  output logic [31:0]               adder_potential,
  output logic                      adder_set,
  output logic                      adder_clear,
  input  logic [31:0]               adder_final,
  input  logic                      adder_spike,
  output logic                      pot_wr_en,
  output logic [31:0]               pot_wr_data,
  output logic                      wgt_clr_en,
  output logic [ADDR_W:0]           spike_count,
  neuron_update_scheduler_if.master spk
);

  typedef enum logic [2:0] {
    S_IDLE, S_SET, S_RD, S_LD, S_EVAL, S_WB, S_SPK, S_DONE
  } state_t;

  localparam int                CNT_W    = (ADD_LAT > 1) ? $clog2(ADD_LAT) : 1;
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(ADD_LAT - 1);
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_NEURONS - 1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] spike_id_q;
  logic [CNT_W-1:0]  settle_cnt;
  logic              last_idx;
  logic              advance;

  assign last_idx     = (idx == LAST_IDX);
  assign mem_addr     = idx;
  assign spk.spike_id = spike_id_q;

  // NOTE: every output of this block gets a default before the case so that
  // no path leaves a signal unassigned, which would infer a latch.
  always_comb begin
    state_nxt       = state;
    busy            = (state != S_IDLE);
    done            = 1'b0;
    mem_rd_en       = 1'b0;
    adder_set       = 1'b0;
    adder_clear     = 1'b0;
    pot_wr_en       = 1'b0;
    wgt_clr_en      = 1'b0;
    pot_wr_data     = '0;
    spk.spike_valid = 1'b0;
    advance         = 1'b0;
    unique case (state)
      S_IDLE: begin
        adder_clear = 1'b1;
        if (start) state_nxt = S_SET;
      end
      S_SET: begin
        adder_set = 1'b1;
        state_nxt = S_RD;
      end
      S_RD: begin
        mem_rd_en = 1'b1;
        state_nxt = S_LD;
      end
      S_LD:   state_nxt = S_EVAL;
      S_EVAL: if (settle_cnt == '0) state_nxt = S_WB;
      S_WB: begin
        pot_wr_en   = 1'b1;
        wgt_clr_en  = 1'b1;
        pot_wr_data = adder_final;
        if (adder_spike) begin
          state_nxt = S_SPK;
        end else begin
          advance   = 1'b1;
          state_nxt = last_idx ? S_DONE : S_RD;
        end
      end
      S_SPK: begin
        spk.spike_valid = 1'b1;
        if (spk.spike_ready) begin
          advance   = 1'b1;
          state_nxt = last_idx ? S_DONE : S_RD;
        end
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx             <= '0;
      spike_count     <= '0;
      adder_weight    <= '0;
      adder_potential <= '0;
      settle_cnt      <= '0;
      spike_id_q      <= '0;
    end else begin
      case (state)
        S_IDLE: if (start) begin
          idx         <= '0;
          spike_count <= '0;
        end
        // Operands are captured once per neuron and held through EVAL so the
        // combinational adder sees stable inputs while it settles.
        S_LD: begin
          adder_weight    <= wgt_rd_data;
          adder_potential <= pot_rd_data;
          settle_cnt      <= CNT_LOAD;
        end
        S_EVAL: if (settle_cnt != '0) settle_cnt <= settle_cnt - 1'b1;
        S_WB: if (adder_spike) begin
          spike_id_q  <= idx;
          spike_count <= spike_count + 1'b1;
        end
        default: ;
      endcase
      if (advance && !last_idx) idx <= idx + 1'b1;
    end
  end

endmodule

// File: tb/tb_neuron_update_scheduler.sv
// Self-checking bench: table-driven timesteps on a 20-neuron / 2-cycle instance,
// plus directed threshold, reset and single-neuron corner sequences.
module tb_neuron_update_scheduler;

  localparam int NUM = 20;
  localparam int AW  = 5;
  localparam int LAT = 2;
  localparam int NV  = 5;

  typedef struct packed {
    logic [31:0] mask;
    int          stall;
    bit          rdy_hi;
    int          restart_at;
    int          exp_cycles;
    int          exp_spikes;
    int          exp_spk_cycles;
  } vec_t;

  int checks = 0;
  int errors = 0;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n  = 1'b0;
  logic start  = 1'b0;
  logic start1 = 1'b0;

  // Main instance
  logic          busy, done, mem_rd_en, adder_set, adder_clear, adder_spike;
  logic          pot_wr_en, wgt_clr_en;
  logic [AW-1:0] mem_addr;
  logic [31:0]   wgt_rd_data = '0;
  logic [31:0]   pot_rd_data = '0;
  logic [31:0]   adder_weight, adder_potential, adder_final, pot_wr_data;
  logic [AW:0]   spike_count;
  neuron_update_scheduler_if #(.ADDR_W(AW)) sif();

  // Single-neuron, single-cycle-settle instance
  logic          busy1, done1, mem_rd_en1, adder_set1, adder_clear1;
  logic          pot_wr_en1, wgt_clr_en1;
  logic [AW-1:0] mem_addr1;
  logic [31:0]   adder_weight1, adder_potential1, adder_final1, pot_wr_data1;
  logic [AW:0]   spike_count1;
  neuron_update_scheduler_if #(.ADDR_W(AW)) sif1();

  neuron_update_scheduler #(.NUM_NEURONS(NUM), .ADDR_W(AW), .ADD_LAT(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
    .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .wgt_rd_data(wgt_rd_data), .pot_rd_data(pot_rd_data),
    .adder_weight(adder_weight), .adder_potential(adder_potential),
    .adder_set(adder_set), .adder_clear(adder_clear),
    .adder_final(adder_final), .adder_spike(adder_spike),
    .pot_wr_en(pot_wr_en), .pot_wr_data(pot_wr_data), .wgt_clr_en(wgt_clr_en),
    .spike_count(spike_count), .spk(sif.master)
  );

  neuron_update_scheduler #(.NUM_NEURONS(1), .ADDR_W(AW), .ADD_LAT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .busy(busy1), .done(done1),
    .mem_rd_en(mem_rd_en1), .mem_addr(mem_addr1),
    .wgt_rd_data(32'd5), .pot_rd_data(32'd0),
    .adder_weight(adder_weight1), .adder_potential(adder_potential1),
    .adder_set(adder_set1), .adder_clear(adder_clear1),
    .adder_final(adder_final1), .adder_spike(1'b0),
    .pot_wr_en(pot_wr_en1), .pot_wr_data(pot_wr_data1), .wgt_clr_en(wgt_clr_en1),
    .spike_count(spike_count1), .spk(sif1.master)
  );

  assign sif1.spike_ready = 1'b1;
  assign adder_final1     = adder_weight1 + 32'd1;

  // Neuron state memory with one-cycle read latency
  logic [31:0] wgt_mem [32];
  logic [31:0] pot_mem [32];
  always @(posedge clk) begin
    if (mem_rd_en) begin
      wgt_rd_data <= wgt_mem[mem_addr];
      pot_rd_data <= pot_mem[mem_addr];
    end
  end

  // Adder model: mode 0 is an integer stub, mode 1 a floating-point threshold
  // adder whose 100.0 threshold only takes effect once adder_set was seen.
  logic        adder_mode = 1'b0;
  logic [31:0] spike_mask = '0;
  bit          thr_armed  = 1'b0;
  logic        fire;

  function automatic real sp2r(input logic [31:0] b);
    logic [10:0] e;
    if (b[30:0] == 31'd0) return 0.0;
    e = {3'b000, b[30:23]} + 11'd896;
    return $bitstoreal({b[31], e, b[22:0], 29'd0});
  endfunction

  assign fire        = thr_armed && ((sp2r(adder_weight) + sp2r(adder_potential)) >= 100.0);
  assign adder_final = adder_mode ? (fire ? 32'h3F80_0000 : 32'h0) : adder_weight + 32'd1;
  assign adder_spike = !adder_clear && (adder_mode ? fire : spike_mask[mem_addr]);

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitor / spike consumer, all sampled on the falling edge
  int          cyc = 0;
  int          start_cyc = 0, done_cyc = 0, done_cnt = 0, wr_cnt = 0;
  int          spk_cnt = 0, set_cyc = -1, rd_cyc = -1, valid_cycles = 0, stall_cnt = 0;
  int          stall_first = 0;
  bit          ready_hi = 1'b0;
  bit          in_spk = 1'b0;
  logic [AW-1:0] held_id = '0;
  logic [AW-1:0] wr_addr [64];
  logic [31:0]   wr_data [64];
  logic [AW-1:0] spk_ids [32];
  int          start1_cyc = 0, done1_cyc = 0, done1_cnt = 0, wr1_cnt = 0, wr1_cyc = 0;
  logic [31:0] wr1_data = '0;
  logic [AW-1:0] wr1_addr = '0;

  initial begin
    sif.spike_ready = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        sif.spike_ready = 1'b0;
        in_spk          = 1'b0;
      end else begin
        if (start && !busy) begin
          start_cyc = cyc; done_cnt = 0; wr_cnt = 0; spk_cnt = 0;
          set_cyc = -1; rd_cyc = -1; valid_cycles = 0; stall_cnt = 0; thr_armed = 1'b0;
        end
        if (adder_set) begin
          thr_armed = 1'b1;
          if (set_cyc < 0) set_cyc = cyc;
        end
        if (mem_rd_en && rd_cyc < 0) rd_cyc = cyc;
        if (pot_wr_en) begin
          check("wgt_clr_with_wr", wgt_clr_en, 1);
          if (wr_cnt < 64) begin
            wr_addr[wr_cnt] = mem_addr;
            wr_data[wr_cnt] = pot_wr_data;
          end
          wr_cnt++;
        end
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
        end
        if (sif.spike_valid) begin
          valid_cycles++;
          if (!in_spk) begin
            in_spk  = 1'b1;
            held_id = sif.spike_id;
          end else begin
            check("spike_id_stable", sif.spike_id, held_id);
          end
          if (!ready_hi && spk_cnt == 0 && stall_cnt < stall_first) begin
            sif.spike_ready = 1'b0;
            stall_cnt++;
          end else begin
            sif.spike_ready = 1'b1;
          end
          if (sif.spike_ready) begin
            if (spk_cnt < 32) spk_ids[spk_cnt] = sif.spike_id;
            spk_cnt++;
            in_spk = 1'b0;
          end
        end else begin
          sif.spike_ready = ready_hi;
        end
        if (start1 && !busy1) begin
          start1_cyc = cyc; done1_cnt = 0; wr1_cnt = 0;
        end
        if (pot_wr_en1) begin
          wr1_cnt++; wr1_cyc = cyc; wr1_data = pot_wr_data1; wr1_addr = mem_addr1;
        end
        if (done1) begin
          done1_cnt++; done1_cyc = cyc;
        end
      end
    end
  end

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    check("done_within_budget", done_cnt != 0, 1);
  endtask

  task automatic check_reset_outputs();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_en", mem_rd_en, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_wgt_op", adder_weight, 0);
    check("rst_pot_op", adder_potential, 0);
    check("rst_set", adder_set, 0);
    check("rst_clear", adder_clear, 1);
    check("rst_wr_en", pot_wr_en, 0);
    check("rst_clr_en", wgt_clr_en, 0);
    check("rst_spike_count", spike_count, 0);
    check("rst_spike_valid", sif.spike_valid, 0);
    check("rst_spike_id", sif.spike_id, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t vecs [NV];

  initial begin
    int j;
    vecs[0] = '{mask: 32'h0,     stall: 0, rdy_hi: 1'b0, restart_at: 0,  exp_cycles: 102, exp_spikes: 0,  exp_spk_cycles: 0};
    vecs[1] = '{mask: 32'h80001, stall: 5, rdy_hi: 1'b0, restart_at: 0,  exp_cycles: 109, exp_spikes: 2,  exp_spk_cycles: 7};
    vecs[2] = '{mask: 32'h38,    stall: 0, rdy_hi: 1'b1, restart_at: 0,  exp_cycles: 105, exp_spikes: 3,  exp_spk_cycles: 3};
    vecs[3] = '{mask: 32'hFFFFF, stall: 0, rdy_hi: 1'b0, restart_at: 0,  exp_cycles: 122, exp_spikes: 20, exp_spk_cycles: 20};
    vecs[4] = '{mask: 32'h0,     stall: 0, rdy_hi: 1'b1, restart_at: 30, exp_cycles: 102, exp_spikes: 0,  exp_spk_cycles: 0};

    repeat (3) @(posedge clk);
    #1 check_reset_outputs();
    rst_n = 1'b1;

    for (int v = 0; v < NV; v++) begin
      spike_mask  = vecs[v].mask;
      stall_first = vecs[v].stall;
      ready_hi    = vecs[v].rdy_hi;
      adder_mode  = 1'b0;
      for (int i = 0; i < 32; i++) begin
        wgt_mem[i] = i + v * 256;
        pot_mem[i] = 32'h4000_0000 | i;
      end
      @(posedge clk); #1;
      check("idle_not_busy", busy, 0);
      pulse_start();
      check("busy_after_start", busy, 1);
      if (vecs[v].restart_at > 0) begin
        repeat (vecs[v].restart_at) @(posedge clk);
        pulse_start();
      end
      wait_done(400);
      repeat (3) @(posedge clk);
      check("latency", done_cyc - start_cyc, vecs[v].exp_cycles);
      check("single_done", done_cnt, 1);
      check("idle_after_done", busy, 0);
      check("spike_count", spike_count, vecs[v].exp_spikes);
      check("spike_events", spk_cnt, vecs[v].exp_spikes);
      check("spike_valid_cycles", valid_cycles, vecs[v].exp_spk_cycles);
      check("write_count", wr_cnt, NUM);
      for (int i = 0; i < NUM; i++) begin
        check("wr_addr_order", wr_addr[i], i);
        check("wr_data", wr_data[i], i + v * 256 + 1);
      end
      j = 0;
      for (int i = 0; i < NUM; i++) begin
        if (vecs[v].mask[i] && j < 32) begin
          check("spike_id", spk_ids[j], i);
          j++;
        end
      end
    end

    // Threshold crossing on neuron 7 with the floating-point adder model
    adder_mode  = 1'b1;
    stall_first = 0;
    ready_hi    = 1'b0;
    for (int i = 0; i < 32; i++) begin
      wgt_mem[i] = '0;
      pot_mem[i] = '0;
    end
    wgt_mem[7] = 32'h4247_0A3D;
    pot_mem[7] = 32'h425E_D852;
    pulse_start();
    wait_done(400);
    repeat (2) @(posedge clk);
    check("thr_set_cycle", set_cyc - start_cyc, 1);
    check("thr_first_rd_cycle", rd_cyc - start_cyc, 2);
    check("thr_latency", done_cyc - start_cyc, 103);
    check("thr_spike_events", spk_cnt, 1);
    check("thr_spike_id", spk_ids[0], 7);
    check("thr_spike_count", spike_count, 1);
    check("thr_wr7_data", wr_data[7], 32'h3F80_0000);
    check("thr_wr6_data", wr_data[6], 32'h0);

    // Reset asserted in EVAL of neuron 2, after a spike on neuron 0
    adder_mode = 1'b0;
    spike_mask = 32'h1;
    ready_hi   = 1'b1;
    for (int i = 0; i < 32; i++) wgt_mem[i] = i + 5;
    pulse_start();
    repeat (14) @(posedge clk);
    #1;
    check("pre_reset_addr", mem_addr, 2);
    check("pre_reset_operand", adder_weight, 7);
    check("pre_reset_count", spike_count, 1);
    rst_n = 1'b0;
    #1 check_reset_outputs();
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("rst_no_write", pot_wr_en, 0);
      check("rst_no_done", done, 0);
    end
    rst_n = 1'b1;
    pulse_start();
    wait_done(400);
    repeat (2) @(posedge clk);
    check("post_reset_latency", done_cyc - start_cyc, 103);
    check("post_reset_writes", wr_cnt, NUM);
    check("post_reset_count", spike_count, 1);

    // Single neuron, single-cycle settle
    @(posedge clk); #1 start1 = 1'b1;
    @(posedge clk); #1 start1 = 1'b0;
    for (int n = 0; n < 50 && done1_cnt == 0; n++) @(posedge clk);
    repeat (2) @(posedge clk);
    check("n1_done_seen", done1_cnt, 1);
    check("n1_latency", done1_cyc - start1_cyc, 6);
    check("n1_wb_cycle", wr1_cyc - start1_cyc, 5);
    check("n1_writes", wr1_cnt, 1);
    check("n1_wr_data", wr1_data, 6);
    check("n1_wr_addr", wr1_addr, 0);
    check("n1_spike_count", spike_count1, 0);
    check("n1_idle", busy1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/neuron_update_scheduler.md
# neuron_update_scheduler

Timestep sequencer for the shared LIF potential adder in the 20-neuron cluster. On each `start` pulse it loads the adder's threshold and model setting, then walks every neuron index in order. For each neuron it reads the accumulated input weight and the decayed potential from the neuron state memory and presents them to the adder. After the adder settles it writes the final potential back, clears the weight accumulator, and emits a spike event for each firing neuron over a valid/ready handshake.

## Interface
- `NUM_NEURONS`, 20, neurons serviced per timestep (≥1)
- `ADDR_W`, 5, neuron index width; 2^ADDR_W ≥ NUM_NEURONS
- `ADD_LAT`, 2, cycles allowed for the combinational FP adder/comparator to settle (≥1)
- `clk` in 1: single clock, rising edge
- `rst_n` in 1: asynchronous, active-low reset
- `start` in 1: 1-cycle pulse, begins a timestep; ignored unless IDLE
- `busy` out 1: high in every state except IDLE
- `done` out 1: 1-cycle pulse after last neuron written back
- `mem_rd_en` out 1: read strobe; data valid next cycle
- `mem_addr` out ADDR_W: neuron index for read and write
- `wgt_rd_data` in 32: accumulated weight (IEEE-754 single)
- `pot_rd_data` in 32: decayed potential (IEEE-754 single)
- `adder_weight` out 32: registered operand to adder `input_weight`
- `adder_potential` out 32: registered operand to adder `decayed_potential`
- `adder_set` out 1: adder configuration strobe
- `adder_clear` out 1: holds adder spike low
- `adder_final` in 32: adder final potential
- `adder_spike` in 1: adder spike flag
- `pot_wr_en` out 1: potential write strobe at `mem_addr`
- `pot_wr_data` out 32: value written (= `adder_final` sampled in WB)
- `wgt_clr_en` out 1: zero accumulator at `mem_addr`, coincident with `pot_wr_en`
- `spike_valid` out 1, `spike_id` out ADDR_W, `spike_ready` in 1: spike event handshake
- `spike_count` out ADDR_W+1: spikes emitted this timestep

## Operation
- States: IDLE, SET, RD, LD, EVAL, WB, SPK, DONE.
- IDLE:
  - `adder_clear`=1.
  - On `start`: clear `idx`, clear `spike_count`, go to SET.
- SET (1 cycle): `adder_set`=1, `adder_clear`=0. Go to RD.
- RD (1 cycle): `mem_rd_en`=1, `mem_addr`=idx. Go to LD.
- LD (1 cycle): register `wgt_rd_data` into `adder_weight` and `pot_rd_data` into `adder_potential`. Load the settle counter with ADD_LAT-1. Go to EVAL.
- EVAL: hold operands; decrement the counter. At 0, go to WB. Stay time is exactly ADD_LAT cycles.
- WB (1 cycle):
  - `pot_wr_en`=`wgt_clr_en`=1; `pot_wr_data`=`adder_final`.
  - Sample `adder_spike`. If 1: set `spike_id`=idx, increment `spike_count`, go to SPK.
  - Else go to next.
- SPK: `spike_valid`=1 with `spike_id` stable until a cycle with `spike_ready`=1, then go to next.
- next: if idx==NUM_NEURONS-1, go to DONE; else idx+1 and go to RD.
- DONE (1 cycle): `done`=1, go to IDLE. `spike_count` holds its value until the next `start`.
- `mem_addr` holds idx in RD through SPK.
- Operands change only in LD.
- `start` while busy is ignored; it is not queued.

## Timing
- Reset (async assert, sync deassert):
  - State goes to IDLE.
  - Outputs go to 0: idx, `spike_count`, `adder_weight`, `adder_potential`, `spike_id`, and all strobes.
  - `adder_clear`=1.
- `busy` rises the cycle after `start`.
- Per-neuron cycles: ADD_LAT+3 with no spike; ADD_LAT+3+k with a spike, where k≥1 is the SPK cycles up to and including the `spike_ready` cycle.
- Timestep cycles: 2 + NUM_NEURONS·(ADD_LAT+3) + Σk. Example: 102 cycles for defaults with no spikes or backpressure.
- `spike_ready` already high on SPK entry: transfer in the first SPK cycle (k=1).
- `spike_ready` high outside SPK: no effect.
- Reset mid-timestep: no further write, no `done`, and any pending spike event is dropped.
- NUM_NEURONS=1: SET, RD, LD, EVAL, WB, DONE.
- `spike_count` cannot exceed NUM_NEURONS; no saturation logic is needed.

## Test plan
- **Reset:** drive `rst_n`=0 mid-EVAL.
  - Expect all outputs 0, `adder_clear`=1, and no `pot_wr_en`.
  - After release, `start` runs a full timestep.
- **No spikes:** stub adder with `adder_final`=`wgt_rd_data`+1 (integer) and `adder_spike`=0; memory weight[i]=i.
  - Expect 20 writes in order with `pot_wr_data`=i+1.
  - Expect `done` at cycle 102 after `start`, `spike_count`=0, and no `spike_valid`.
- **Threshold crossing:** real adder, weight 0x42470A3D and potential 0x425ED852 at neuron 7, others 0.
  - Expect SET pulse before the first RD.
  - Expect exactly one `spike_valid` with `spike_id`=7 and `spike_count`=1.
  - Expect `pot_wr_data`[7] = `adder_final` sampled in WB.
- **Backpressure:** stub spikes at neurons 0 and 19; hold `spike_ready` low 5 cycles on the first event, high on the second.
  - Expect `spike_id` stable for 6 cycles, then 1-cycle transfer.
  - Expect `done` at 102+7.
- **Start ignored:** pulse `start` while busy.
  - Expect no restart, idx sequence unbroken, and a single `done`.
- **Parameter corners:** run with NUM_NEURONS=1 and ADD_LAT=1.
  - Expect total 6 cycles start→done, with WB one cycle after LD+1.
